io_supply_seq: RTL and testbench
================================

Name: io_supply_seq

Overview:
- Parametrised power-up and power-down sequencer for the IO pad-ring supply groups.
- Each channel is one pad group. For each channel the block drives:
  - a pad-enable output;
  - an isolation output.
- Channels are released in ascending order once all supply power-good inputs are stable, and shut down in descending order.
- Sits beside the pad ring in the always-on core domain. It replaces the hard-wired, non-sequenced supply pad arrangement.

Parameters:
- CH, 4, number of pad supply groups / channels (2..16).
- CNT_W, 8, width of the debounce and gap counters and their programming inputs.
- SYNC_STAGES, 2, synchroniser depth on pg_i (minimum 2).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  1  power-up request (1 = bring pads up, 0 = shut down).
- pg_i  in  CH  per-channel supply power-good. Asynchronous; synchronised internally.
- deb_cycles_i  in  CNT_W  debounce length. Sampled while in DEBOUNCE.
- gap_cycles_i  in  CNT_W  inter-channel gap. Sampled while in RAMP/SHUTDOWN.
- pad_en_o  out  CH  pad-group enable, active high.
- iso_o  out  CH  pad-group isolation, active high.
- ready_o  out  1  all channels released (state ON).
- fault_o  out  1  power-good lost while any channel was released.
- state_o  out  3  encoded FSM state: IDLE=0, WAIT_PG=1, DEBOUNCE=2, RAMP=3, ON=4, SHUTDOWN=5, FAULT=6.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low. All flops reset asynchronously.
- Reset values:
  - pad_en_o=0, iso_o=all 1s, ready_o=0, fault_o=0, state_o=IDLE.
  - Synchroniser flops=0, counter=0, index=0.
  - Reset mid-sequence forces these values immediately, with no ordered shutdown.
- pg_s is pg_i after SYNC_STAGES flops. "pg_ok" means &pg_s.
- All outputs are registered. Outputs change one cycle after the state/condition that causes them.
- IDLE:
  - Outputs are held at their reset values.
  - req_i=1 -> WAIT_PG.
- WAIT_PG:
  - req_i=0 -> IDLE.
  - Else pg_ok -> DEBOUNCE with cnt=0.
- DEBOUNCE:
  - req_i=0 -> IDLE.
  - !pg_ok -> WAIT_PG.
  - Else if cnt==deb_cycles_i -> RAMP with cnt=0, idx=0.
  - Else cnt++.
  - DEBOUNCE therefore lasts deb_cycles_i+1 cycles; deb_cycles_i=0 gives 1 cycle.
- RAMP:
  - When cnt==0, release channel idx: pad_en[idx]<=1 and iso[idx]<=0 in the same edge.
  - If idx==CH-1, go to ON next.
  - Otherwise cnt counts up to gap_cycles_i; at equality cnt<=0 and idx++.
  - Consecutive releases are therefore gap_cycles_i+1 cycles apart.
- ON:
  - ready_o=1 while in this state.
  - req_i=0 -> SHUTDOWN with idx=CH-1, cnt=0.
- SHUTDOWN:
  - When cnt==0, drop channel idx: iso[idx]<=1 and pad_en[idx]<=0.
  - If idx==0, go to IDLE next.
  - Otherwise the same gap counting applies, with idx--.
  - req_i re-asserting during SHUTDOWN is ignored until IDLE is reached.
- req_i=0 during RAMP:
  - If at least one channel is released -> SHUTDOWN starting at the highest released channel.
  - If none are released -> IDLE.
- Power-good loss (!pg_ok) in RAMP, ON or SHUTDOWN -> FAULT.
  - On the next edge, all pad_en_o=0 and iso_o=all 1s simultaneously (no ordering).
  - fault_o=1.
- FAULT:
  - Outputs are held safe.
  - Exit to IDLE only when req_i=0. fault_o clears on that exit.
  - pg recovery alone does not exit FAULT.
- Priority when events coincide: pg loss > req_i drop > counter progress.
- Counters saturate-free. A gap or debounce value changed mid-count takes effect at the next compare. If the new value is below the current cnt, the counter wraps at 2^CNT_W before matching; this is a documented hazard, and software changes these values only in IDLE.
- Invariant, every cycle: for each channel, pad_en_o[k] == ~iso_o[k].

Test Plan:
- Nominal ramp (CH=4, deb=3, gap=2, pg_i=4'hF, then req_i 0->1):
  - DEBOUNCE lasts 4 cycles.
  - pad_en_o rises 0001, 0011, 0111, 1111 at 3-cycle spacing.
  - ready_o=1 one cycle after pad_en_o=1111.
  - iso_o is the complement throughout.
- Ordered shutdown (from ON, req_i 1->0):
  - pad_en_o falls 0111, 0011, 0001, 0000 at 3-cycle spacing.
  - State returns to IDLE; ready_o=0 on the first drop.
- Debounce glitch (pg_i[2] low for 1 cycle during DEBOUNCE): state returns to WAIT_PG, then restarts the full debounce; no channel is released early.
- Fault:
  - In ON, pg_i[1]->0. After 2 sync cycles plus 1, pad_en_o=0000, iso_o=1111, fault_o=1, state_o=6.
  - pg_i restored: state stays FAULT.
  - req_i=0: IDLE, fault_o=0.
- Abort mid-ramp (req_i=0 right after pad_en_o=0011): shutdown drops channel 1, then channel 0, then IDLE. Channels 2 and 3 are never enabled.
- Async reset asserted in ON: all outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/io_supply_seq.sv
// Ordered power-up/power-down sequencer for the IO pad-ring supply groups.
// Releases pad groups in ascending order after a debounced power-good and drops them in descending order.
module io_supply_seq #(
  parameter int CH          = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic [CH-1:0]    pg_i,
  input  logic [CNT_W-1:0] deb_cycles_i,
  input  logic [CNT_W-1:0] gap_cycles_i,
  output logic [CH-1:0]    pad_en_o,
  output logic [CH-1:0]    iso_o,
  output logic             ready_o,
  output logic             fault_o,
  output logic [2:0]       state_o
);

  localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CH - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PG  = 3'd1,
    DEBOUNCE = 3'd2,
    RAMP     = 3'd3,
    ON       = 3'd4,
    SHUTDOWN = 3'd5,
    FAULT    = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [CH-1:0]    pad_en;
  logic [CH-1:0]    iso;
  logic             ready;
  logic             fault;
  logic [CH-1:0]    sync_q [SYNC_STAGES];
  logic             pg_ok;

  // pg_i is asynchronous to clk; only the last stage feeds the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pg_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pg_ok = &sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      pad_en <= '0;
      iso    <= '1;
      ready  <= 1'b0;
      fault  <= 1'b0;
    end else begin
      // ready lags the ON state by one edge and drops at once on pg loss
      ready <= (state == ON) && pg_ok;
      case (state)
        IDLE: begin
          pad_en <= '0;
          iso    <= '1;
          fault  <= 1'b0;
          if (req_i) state <= WAIT_PG;
        end
        WAIT_PG: begin
          if (!req_i) begin
            state <= IDLE;
          end else if (pg_ok) begin
            state <= DEBOUNCE;
            cnt   <= '0;
          end
        end
        DEBOUNCE: begin
          if (!req_i) begin
            state <= IDLE;
          end else if (!pg_ok) begin
            state <= WAIT_PG;
          end else if (cnt == deb_cycles_i) begin
            state <= RAMP;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RAMP: begin
          if (!pg_ok) begin
            state  <= FAULT;
            pad_en <= '0;
            iso    <= '1;
            fault  <= 1'b1;
          end else if (!req_i) begin
            // with cnt==0 channel idx is not yet out, so the highest released one is idx-1
            if ((cnt != '0) || (idx != '0)) begin
              state <= SHUTDOWN;
              idx   <= (cnt == '0) ? idx - 1'b1 : idx;
              cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (cnt == '0) begin
              pad_en[idx] <= 1'b1;
              iso[idx]    <= 1'b0;
            end
            if ((cnt == '0) && (idx == LAST)) begin
              state <= ON;
            end else if (cnt == gap_cycles_i) begin
              cnt <= '0;
              idx <= idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ON: begin
          if (!pg_ok) begin
            state  <= FAULT;
            pad_en <= '0;
            iso    <= '1;
            fault  <= 1'b1;
          end else if (!req_i) begin
            state <= SHUTDOWN;
            idx   <= LAST;
            cnt   <= '0;
          end
        end
        SHUTDOWN: begin
          if (!pg_ok) begin
            state  <= FAULT;
            pad_en <= '0;
            iso    <= '1;
            fault  <= 1'b1;
          end else begin
            if (cnt == '0) begin
              pad_en[idx] <= 1'b0;
              iso[idx]    <= 1'b1;
            end
            if ((cnt == '0) && (idx == '0)) begin
              state <= IDLE;
            end else if (cnt == gap_cycles_i) begin
              cnt <= '0;
              idx <= idx - 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FAULT: begin
          pad_en <= '0;
          iso    <= '1;
          fault  <= 1'b1;
          // pg recovery alone never leaves FAULT; software must drop req
          if (!req_i) begin
            state <= IDLE;
            fault <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          pad_en <= '0;
          iso    <= '1;
          fault  <= 1'b0;
        end
      endcase
    end
  end

  assign pad_en_o = pad_en;
  assign iso_o    = iso;
  assign ready_o  = ready;
  assign fault_o  = fault;
  assign state_o  = state;

endmodule

// File: tb/tb_io_supply_seq.sv
// Directed bench for io_supply_seq: ramp, ordered shutdown, debounce glitch, fault, abort and async reset.
module tb_io_supply_seq;
  localparam int CH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req;
  logic [CH-1:0]    pg;
  logic [CNT_W-1:0] deb;
  logic [CNT_W-1:0] gap;
  logic [CH-1:0]    pad_en;
  logic [CH-1:0]    iso;
  logic             ready;
  logic             fault;
  logic [2:0]       state;

  int total = 0;
  int bad = 0;
  logic [CH-1:0] seen;

  io_supply_seq #(.CH(CH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .pg_i         (pg),
    .deb_cycles_i (deb),
    .gap_cycles_i (gap),
    .pad_en_o     (pad_en),
    .iso_o        (iso),
    .ready_o      (ready),
    .fault_o      (fault),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance n edges, sampling 1 time unit after each; iso must always be ~pad_en
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      seen = seen | pad_en;
      chk("pad_iso_complement", 32'(pad_en ^ iso), 32'hF);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    pg    = '0;
    deb   = 8'd3;
    gap   = 8'd2;
    seen  = '0;
    #12;
    chk("rst_pad_en", 32'(pad_en), 32'h0);
    chk("rst_iso", 32'(iso), 32'hF);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    pg = 4'hF;
    #10 rst_n = 1'b1;
    step(4);
    chk("idle_state", 32'(state), 32'h0);

    // nominal ramp
    req = 1'b1;
    step(1); chk("ramp_wait_pg", 32'(state), 32'h1);
    step(1); chk("ramp_deb_first", 32'(state), 32'h2);
    step(3); chk("ramp_deb_last", 32'(state), 32'h2);
    step(1); chk("ramp_enter", 32'(state), 32'h3);
    chk("ramp_enter_pad", 32'(pad_en), 32'h0);
    for (int k = 0; k < CH; k++) begin
      step(1);
      chk("ramp_release", 32'(pad_en), (32'h1 << (k + 1)) - 1);
      chk("ramp_iso", 32'(iso), 32'hF & ~((32'h1 << (k + 1)) - 1));
      if (k < CH - 1) begin
        step(2);
        chk("ramp_hold", 32'(pad_en), (32'h1 << (k + 1)) - 1);
      end
    end
    chk("ramp_on_state", 32'(state), 32'h4);
    chk("ramp_ready_lag", 32'(ready), 32'h0);
    step(1); chk("ramp_ready", 32'(ready), 32'h1);

    // ordered shutdown
    req = 1'b0;
    step(1);
    chk("shut_state", 32'(state), 32'h5);
    chk("shut_pad_hold", 32'(pad_en), 32'hF);
    chk("shut_ready_hold", 32'(ready), 32'h1);
    for (int k = 0; k < CH; k++) begin
      step(1);
      chk("shut_drop", 32'(pad_en), (32'h1 << (CH - 1 - k)) - 1);
      chk("shut_ready", 32'(ready), 32'h0);
      if (k < CH - 1) begin
        step(2);
        chk("shut_hold", 32'(pad_en), (32'h1 << (CH - 1 - k)) - 1);
      end
    end
    chk("shut_idle", 32'(state), 32'h0);

    // debounce glitch on pg[2]
    req = 1'b1;
    step(2); chk("glitch_deb", 32'(state), 32'h2);
    pg = 4'b1011;
    step(1);
    pg = 4'hF;
    step(1); chk("glitch_still_deb", 32'(state), 32'h2);
    step(1); chk("glitch_back_wait", 32'(state), 32'h1);
    step(1); chk("glitch_redeb", 32'(state), 32'h2);
    step(3); chk("glitch_deb_full", 32'(state), 32'h2);
    chk("glitch_no_early", 32'(pad_en), 32'h0);
    step(1); chk("glitch_ramp", 32'(state), 32'h3);
    step(1); chk("glitch_first", 32'(pad_en), 32'h1);
    step(10); chk("glitch_ready", 32'(ready), 32'h1);

    // power-good loss in ON
    pg = 4'b1101;
    step(2);
    chk("fault_sync_delay", 32'(pad_en), 32'hF);
    step(1);
    chk("fault_pad", 32'(pad_en), 32'h0);
    chk("fault_iso", 32'(iso), 32'hF);
    chk("fault_flag", 32'(fault), 32'h1);
    chk("fault_state", 32'(state), 32'h6);
    chk("fault_ready", 32'(ready), 32'h0);
    pg = 4'hF;
    step(5);
    chk("fault_sticky", 32'(state), 32'h6);
    chk("fault_sticky_flag", 32'(fault), 32'h1);
    req = 1'b0;
    step(1);
    chk("fault_exit", 32'(state), 32'h0);
    chk("fault_clear", 32'(fault), 32'h0);

    // abort mid-ramp after 0011
    req = 1'b1;
    step(6); chk("abort_ramp", 32'(state), 32'h3);
    step(1); chk("abort_ch0", 32'(pad_en), 32'h1);
    step(3); chk("abort_ch1", 32'(pad_en), 32'h3);
    seen = '0;
    req = 1'b0;
    step(1);
    chk("abort_shut", 32'(state), 32'h5);
    chk("abort_hold", 32'(pad_en), 32'h3);
    step(1); chk("abort_drop1", 32'(pad_en), 32'h1);
    step(3); chk("abort_drop0", 32'(pad_en), 32'h0);
    chk("abort_idle", 32'(state), 32'h0);
    chk("abort_upper_never", 32'(seen[3:2]), 32'h0);

    // async reset from ON, checked between edges
    req = 1'b1;
    step(17);
    chk("areset_pre_ready", 32'(ready), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_pad", 32'(pad_en), 32'h0);
    chk("areset_iso", 32'(iso), 32'hF);
    chk("areset_ready", 32'(ready), 32'h0);
    chk("areset_fault", 32'(fault), 32'h0);
    chk("areset_state", 32'(state), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
